ps2_scancode_rx: RTL

Receives PS/2 keyboard frames from the board's PS2_CLK/PS2_DAT pins and delivers validated make codes as one-cycle strobes. It is the producer side of the arrow-position logic: `scan_code` and `code_valid` drive that block's `direction` and `enable` inputs directly. Break sequences (F0 xx) are consumed internally, so one key press yields exactly one strobe. Extended sequences (E0 xx) are flagged on `code_ext`.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_scancode_rx_if.sv | 13 +
 rtl/ps2_sync_edge.sv | 36 +++
 rtl/ps2_scancode_rx.sv | 113 +++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and frame FSM encoding.
// Used by the receiver and by anything that decodes its output.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_KEY_A = 8'h1C;
  localparam logic [7:0] SC_KEY_D = 8'h23;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DATA   = 2'd1;
  localparam state_t ST_PARITY = 2'd2;
  localparam state_t ST_STOP   = 2'd3;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Decoded scan-code bus from the PS/2 receiver to its consumer.
// No backpressure: code_valid/frame_error are fire-and-forget strobes.
interface ps2_scancode_rx_if;

  logic [7:0] scan_code;
  logic       code_valid;
  logic       code_ext;
  logic       frame_error;

  modport master (output scan_code, output code_valid, output code_ext, output frame_error);
  modport slave  (input  scan_code, input  code_valid, input  code_ext, input  frame_error);

endinterface

// File: rtl/ps2_sync_edge.sv
// 2-FF synchronizer for PS2 clock/data plus registered clock falling-edge detect; 3 cycles pin-to-fall.
// No backpressure: fall is a one-cycle pulse, dat is aligned with it.
module ps2_sync_edge (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat
);

  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fall   <= 1'b0;
      dat    <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
      // Data is registered alongside the edge so the FSM sees both in the same cycle.
      fall   <= clk_s3 & ~clk_s2;
      dat    <= dat_s2;
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver with break/extended filtering; code_valid 4 cycles after the stop-bit edge.
// No backpressure: each delivered make code is a single-cycle strobe the consumer must take.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit FILTER_BREAK   = 1'b1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               PS2_CLK,
  input  logic               PS2_DAT,
  ps2_scancode_rx_if.master  kb
);

  localparam logic [17:0] TMO = 18'(TIMEOUT_CYCLES);

  logic        fall, dat;
  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [17:0] tcnt;
  logic        ext_pending, brk_pending;
  logic [7:0]  scan_code_q;
  logic        code_valid_q, code_ext_q, frame_error_q;

  ps2_sync_edge u_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .ps2_clk  (PS2_CLK),
    .ps2_dat  (PS2_DAT),
    .fall     (fall),
    .dat      (dat)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 8'h00;
      par_bit       <= 1'b0;
      tcnt          <= 18'd0;
      ext_pending   <= 1'b0;
      brk_pending   <= 1'b0;
      scan_code_q   <= 8'h00;
      code_valid_q  <= 1'b0;
      code_ext_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      code_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;

      if (state == ST_IDLE || fall) tcnt <= 18'd0;
      else                          tcnt <= tcnt + 18'd1;

      // A stalled keyboard mid-frame abandons the frame and any pending prefix.
      if (state != ST_IDLE && !fall && tcnt == TMO) begin
        state         <= ST_IDLE;
        frame_error_q <= 1'b1;
        ext_pending   <= 1'b0;
        brk_pending   <= 1'b0;
        tcnt          <= 18'd0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!dat) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (dat && odd_parity_ok(shreg, par_bit)) begin
              if (shreg == SC_EXT) begin
                ext_pending <= 1'b1;
              end else if (FILTER_BREAK && shreg == SC_BREAK) begin
                brk_pending <= 1'b1;
              end else if (brk_pending) begin
                brk_pending <= 1'b0;
                ext_pending <= 1'b0;
              end else begin
                scan_code_q  <= shreg;
                code_ext_q   <= ext_pending;
                code_valid_q <= 1'b1;
                ext_pending  <= 1'b0;
              end
            end else begin
              frame_error_q <= 1'b1;
              ext_pending   <= 1'b0;
              brk_pending   <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign kb.scan_code   = scan_code_q;
  assign kb.code_valid  = code_valid_q;
  assign kb.code_ext    = code_ext_q;
  assign kb.frame_error = frame_error_q;

endmodule
